// File: rtl/trap_sequencer_if.sv
// Trap sequencer bundle: per-stage exception codes and pipeline context in,
// flush/redirect control, captured trap CSRs and permission flags out.
// slave  : the trap sequencer itself (consumes i_*, drives o_*).
// master : the pipeline side (drives i_*, observes o_*).
interface trap_sequencer_if;
    logic [3:0]  i_exception_code_f;
    logic [3:0]  i_exception_code_e;
    logic [31:0] i_pc_f;
    logic [31:0] i_pc_e;
    logic [31:0] i_alu_out_e;
    logic        i_stall_d;
    logic        i_flush_d;
    logic        i_mret_e;
    logic        o_kill_e;
    logic        o_flush;
    logic        o_redirect_en;
    logic [31:0] o_redirect_pc;
    logic [31:0] o_mepc;
    logic [31:0] o_mcause;
    logic [31:0] o_mtval;
    logic        o_trap_permission;
    logic        o_reset_permission;
    logic        o_double_fault;

    modport slave (
        input  i_exception_code_f, i_exception_code_e, i_pc_f, i_pc_e, i_alu_out_e,
               i_stall_d, i_flush_d, i_mret_e,
        output o_kill_e, o_flush, o_redirect_en, o_redirect_pc, o_mepc, o_mcause, o_mtval,
               o_trap_permission, o_reset_permission, o_double_fault
    );

    modport master (
        output i_exception_code_f, i_exception_code_e, i_pc_f, i_pc_e, i_alu_out_e,
               i_stall_d, i_flush_d, i_mret_e,
        input  o_kill_e, o_flush, o_redirect_en, o_redirect_pc, o_mepc, o_mcause, o_mtval,
               o_trap_permission, o_reset_permission, o_double_fault
    );
endinterface

// File: rtl/trap_sequencer.sv
// Trap sequencer: carries fetch-stage faults down to E so traps stay precise,
// captures mepc/mcause/mtval, and sequences trap entry, mret return and
// double-fault reset with a one-cycle flush + PC redirect.
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - asynchronous reset, active-high
//   bus    - trap_sequencer_if.slave (exception codes, PCs, hazard controls in;
//            kill/flush/redirect, trap CSRs and permission flags out)
// Exception codes: 0 none, 1 fetch misaligned, 2 illegal, 3 load misaligned,
// 4 load fault, 5 store misaligned, 6 store fault, 7 ecall, 8 SP out of range.
module trap_sequencer #(
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0000,
    parameter logic [31:0] RESET_VECTOR = 32'h0004_0000,
    parameter logic [31:0] SP_CAUSE     = 32'd24
) (
    input logic            i_clk,
    input logic            i_rst,
    trap_sequencer_if.slave bus
);
    localparam logic [3:0] NO_E               = 4'd0;
    localparam logic [3:0] E_FETCH_MISALIGNED = 4'd1;
    localparam logic [3:0] E_ILLEGAL_INSTR    = 4'd2;
    localparam logic [3:0] E_LOAD_MISALIGNED  = 4'd3;
    localparam logic [3:0] E_LOAD_FAULT       = 4'd4;
    localparam logic [3:0] E_STORE_MISALIGNED = 4'd5;
    localparam logic [3:0] E_STORE_FAULT      = 4'd6;
    localparam logic [3:0] E_ECALL            = 4'd7;
    localparam logic [3:0] E_SP_OUT_OF_RANGE  = 4'd8;

    localparam logic [2:0] S_RESET   = 3'd0;
    localparam logic [2:0] S_RUN     = 3'd1;
    localparam logic [2:0] S_ENTRY   = 3'd2;
    localparam logic [2:0] S_IN_TRAP = 3'd3;
    localparam logic [2:0] S_RETURN  = 3'd4;
    localparam logic [2:0] S_DFAULT  = 3'd5;

    logic [2:0]  state, state_next;
    logic [3:0]  fx_d_code, fx_e_code;
    logic [31:0] fx_d_pc, fx_e_pc;
    logic [31:0] mepc, mcause, mtval;
    logic [3:0]  eff_code;
    logic [31:0] eff_pc;
    logic [31:0] cause_next, tval_next;
    logic        exc_e, capture;
    logic        flush, redirect_en;
    logic [31:0] redirect_pc;

    // A carried fetch fault belongs to an older instruction than anything E reports.
    always_comb begin
        if (fx_e_code != NO_E) begin
            eff_code = fx_e_code;
            eff_pc   = fx_e_pc;
        end else begin
            eff_code = bus.i_exception_code_e;
            eff_pc   = bus.i_pc_e;
        end
    end

    assign exc_e = (eff_code != NO_E) && ((state == S_RUN) || (state == S_IN_TRAP));

    always_comb begin
        cause_next = 32'd0;
        tval_next  = 32'd0;
        case (eff_code)
            E_FETCH_MISALIGNED: begin cause_next = 32'd0; tval_next = eff_pc; end
            E_ILLEGAL_INSTR:    cause_next = 32'd2;
            E_LOAD_MISALIGNED:  begin cause_next = 32'd4; tval_next = bus.i_alu_out_e; end
            E_LOAD_FAULT:       begin cause_next = 32'd5; tval_next = bus.i_alu_out_e; end
            E_STORE_MISALIGNED: begin cause_next = 32'd6; tval_next = bus.i_alu_out_e; end
            E_STORE_FAULT:      begin cause_next = 32'd7; tval_next = bus.i_alu_out_e; end
            E_ECALL:            cause_next = 32'd11;
            E_SP_OUT_OF_RANGE:  begin cause_next = SP_CAUSE; tval_next = bus.i_alu_out_e; end
            default:            ;
        endcase
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            S_RESET:   if (bus.i_pc_f[20:18] == 3'b010) state_next = S_RUN;
            S_RUN: begin
                if (exc_e) begin
                    state_next = S_ENTRY;
                    capture    = 1'b1;
                end
            end
            S_ENTRY:   state_next = S_IN_TRAP;
            // A fault inside the handler beats a simultaneous mret.
            S_IN_TRAP: begin
                if (exc_e)              state_next = S_DFAULT;
                else if (bus.i_mret_e)  state_next = S_RETURN;
            end
            S_RETURN:  state_next = S_RUN;
            S_DFAULT:  state_next = S_RESET;
            default:   state_next = S_RESET;
        endcase
    end

    always_comb begin
        flush       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 32'd0;
        case (state)
            S_ENTRY: begin
                flush       = 1'b1;
                redirect_en = 1'b1;
                redirect_pc = TRAP_VECTOR;
            end
            S_RETURN: begin
                flush       = 1'b1;
                redirect_en = 1'b1;
                // ecall resumes after itself; other causes retry the faulting instruction.
                redirect_pc = (mcause == 32'd11) ? mepc + 32'd4 : mepc;
            end
            S_DFAULT: begin
                flush       = 1'b1;
                redirect_en = 1'b1;
                redirect_pc = RESET_VECTOR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= S_RESET;
            fx_d_code <= NO_E;
            fx_e_code <= NO_E;
            fx_d_pc   <= 32'd0;
            fx_e_pc   <= 32'd0;
            mepc      <= 32'd0;
            mcause    <= 32'd0;
            mtval     <= 32'd0;
        end else begin
            state <= state_next;
            if (capture) begin
                mepc   <= eff_pc;
                mcause <= cause_next;
                mtval  <= tval_next;
            end
            // Flush has priority over stall.
            if (flush || bus.i_flush_d) begin
                fx_d_code <= NO_E;
                fx_e_code <= NO_E;
                fx_d_pc   <= 32'd0;
                fx_e_pc   <= 32'd0;
            end else if (!bus.i_stall_d) begin
                fx_d_code <= bus.i_exception_code_f;
                fx_d_pc   <= bus.i_pc_f;
                fx_e_code <= fx_d_code;
                fx_e_pc   <= fx_d_pc;
            end
        end
    end

    assign bus.o_kill_e           = exc_e;
    assign bus.o_flush            = flush;
    assign bus.o_redirect_en      = redirect_en;
    assign bus.o_redirect_pc      = redirect_pc;
    assign bus.o_mepc             = mepc;
    assign bus.o_mcause           = mcause;
    assign bus.o_mtval            = mtval;
    assign bus.o_trap_permission  = (state == S_ENTRY) || (state == S_IN_TRAP);
    assign bus.o_reset_permission = (state == S_RESET);
    assign bus.o_double_fault     = (state == S_DFAULT);
endmodule

// File: tb/tb_trap_sequencer.sv
// Testbench for trap_sequencer: directed scenarios followed by random traffic,
// checked against a cycle-level behavioural model; redirects go through a
// scoreboard queue that a separate monitor drains.
module tb_trap_sequencer;
    localparam logic [3:0] NO_E      = 4'd0;
    localparam logic [3:0] E_FMIS    = 4'd1;
    localparam logic [3:0] E_ILL     = 4'd2;
    localparam logic [3:0] E_LMIS    = 4'd3;
    localparam logic [3:0] E_LFLT    = 4'd4;
    localparam logic [3:0] E_SMIS    = 4'd5;
    localparam logic [3:0] E_SFLT    = 4'd6;
    localparam logic [3:0] E_ECALL   = 4'd7;
    localparam logic [3:0] E_SP      = 4'd8;
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0000;
    localparam logic [31:0] RESET_VEC = 32'h0004_0000;
    localparam logic [31:0] RUN_PC    = 32'h0008_0000;
    localparam logic [31:0] BOOT_PC   = 32'h0004_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] mtval;
        logic        df;
    } redir_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trap_sequencer_if bus();
    trap_sequencer dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    redir_t exp_q[$];

    // Model state: boot region, inside handler, redirect due this cycle.
    bit          m_boot, m_handler, m_busy, m_busy_df;
    logic [31:0] m_mepc, m_mcause, m_mtval;
    logic [3:0]  m_fc[2];
    logic [31:0] m_fp[2];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cause_of(input logic [3:0] c);
        case (c)
            E_FMIS:  return 32'd0;
            E_ILL:   return 32'd2;
            E_LMIS:  return 32'd4;
            E_LFLT:  return 32'd5;
            E_SMIS:  return 32'd6;
            E_SFLT:  return 32'd7;
            E_ECALL: return 32'd11;
            E_SP:    return 32'd24;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] tval_of(input logic [3:0] c, input logic [31:0] pc,
                                            input logic [31:0] alu);
        case (c)
            E_FMIS:                              return pc;
            E_LMIS, E_LFLT, E_SMIS, E_SFLT, E_SP: return alu;
            default:                             return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_boot = 1; m_handler = 0; m_busy = 0; m_busy_df = 0;
        m_mepc = 0; m_mcause = 0; m_mtval = 0;
        for (int i = 0; i < 2; i++) begin m_fc[i] = NO_E; m_fp[i] = 0; end
    endtask

    // Drive one cycle's inputs, advance the model, check the combinational outputs.
    task automatic step(input logic [3:0] cf, input logic [3:0] ce, input logic [31:0] pf,
                        input logic [31:0] pe, input logic [31:0] alu, input bit st,
                        input bit fl, input bit mr);
        logic [3:0]  ec;
        logic [31:0] ep;
        bit          ek, erp, etp, flush_now, df_now;
        redir_t      r;
        bus.i_exception_code_f = cf;
        bus.i_exception_code_e = ce;
        bus.i_pc_f      = pf;
        bus.i_pc_e      = pe;
        bus.i_alu_out_e = alu;
        bus.i_stall_d   = st;
        bus.i_flush_d   = fl;
        bus.i_mret_e    = mr;
        if (m_fc[1] != NO_E) begin ec = m_fc[1]; ep = m_fp[1]; end
        else begin ec = ce; ep = pe; end
        ek = !m_boot && !m_busy && (ec != NO_E);
        erp = m_boot;
        etp = m_handler;
        flush_now = m_busy;
        df_now = m_busy_df;
        if (m_busy) begin
            m_busy = 0; m_busy_df = 0;
            if (df_now) m_boot = 1;
        end else if (m_boot) begin
            if (pf[20:18] == 3'b010) m_boot = 0;
        end else if (ek) begin
            if (m_handler) begin
                r.pc = RESET_VEC; r.df = 1'b1; m_busy_df = 1; m_handler = 0;
            end else begin
                m_mepc = ep; m_mcause = cause_of(ec); m_mtval = tval_of(ec, ep, alu);
                r.pc = TRAP_VEC; r.df = 1'b0; m_handler = 1;
            end
            r.mepc = m_mepc; r.mcause = m_mcause; r.mtval = m_mtval;
            exp_q.push_back(r);
            m_busy = 1;
        end else if (m_handler && mr) begin
            r.pc = (m_mcause == 32'd11) ? m_mepc + 32'd4 : m_mepc;
            r.mepc = m_mepc; r.mcause = m_mcause; r.mtval = m_mtval; r.df = 1'b0;
            exp_q.push_back(r);
            m_handler = 0;
            m_busy = 1;
        end
        if (flush_now || fl) begin
            for (int i = 0; i < 2; i++) begin m_fc[i] = NO_E; m_fp[i] = 0; end
        end else if (!st) begin
            m_fc[1] = m_fc[0]; m_fp[1] = m_fp[0];
            m_fc[0] = cf;      m_fp[0] = pf;
        end
        #1;
        chk1("kill_e", bus.o_kill_e, ek);
        chk1("reset_permission", bus.o_reset_permission, erp);
        chk1("trap_permission", bus.o_trap_permission, etp);
    endtask

    task automatic cyc(input logic [3:0] cf, input logic [3:0] ce, input logic [31:0] pf,
                       input logic [31:0] pe, input logic [31:0] alu, input bit st,
                       input bit fl, input bit mr);
        @(negedge clk);
        step(cf, ce, pf, pe, alu, st, fl, mr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(NO_E, NO_E, RUN_PC, RUN_PC, 32'd0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        model_reset();
        #1;
        chk1("rst_kill", bus.o_kill_e, 1'b0);
        chk1("rst_flush", bus.o_flush, 1'b0);
        chk1("rst_redirect_en", bus.o_redirect_en, 1'b0);
        chk32("rst_redirect_pc", bus.o_redirect_pc, 32'd0);
        chk32("rst_mepc", bus.o_mepc, 32'd0);
        chk32("rst_mcause", bus.o_mcause, 32'd0);
        chk32("rst_mtval", bus.o_mtval, 32'd0);
        chk1("rst_trap_perm", bus.o_trap_permission, 1'b0);
        chk1("rst_reset_perm", bus.o_reset_permission, 1'b1);
        chk1("rst_double_fault", bus.o_double_fault, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(NO_E, NO_E, BOOT_PC, BOOT_PC, 32'd0, 0, 0, 0);
    endtask

    // Monitor: every redirect must match the head of the scoreboard, which is
    // always due on the cycle right after the model pushed it.
    initial begin
        redir_t r;
        forever begin
            @(posedge clk);
            #1;
            if (bus.o_redirect_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_redirect: got pc %h expected no redirect",
                             bus.o_redirect_pc);
                end else begin
                    r = exp_q.pop_front();
                    chk32("redirect_pc", bus.o_redirect_pc, r.pc);
                    chk32("mepc", bus.o_mepc, r.mepc);
                    chk32("mcause", bus.o_mcause, r.mcause);
                    chk32("mtval", bus.o_mtval, r.mtval);
                    chk1("double_fault", bus.o_double_fault, r.df);
                    chk1("flush_with_redirect", bus.o_flush, 1'b1);
                end
            end else if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                checks++; errors++;
                $display("FAIL missing_redirect: got none expected pc %h", r.pc);
            end else begin
                chk1("idle_flush", bus.o_flush, 1'b0);
                chk1("idle_double_fault", bus.o_double_fault, 1'b0);
            end
        end
    end

    initial begin
        logic [3:0]  cf, ce;
        logic [31:0] pf;
        int          r;
        model_reset();
        bus.i_exception_code_f = NO_E; bus.i_exception_code_e = NO_E;
        bus.i_pc_f = BOOT_PC; bus.i_pc_e = BOOT_PC; bus.i_alu_out_e = 0;
        bus.i_stall_d = 0; bus.i_flush_d = 0; bus.i_mret_e = 0;
        do_reset();

        // Boot region, then the run region releases reset permission.
        cyc(NO_E, E_SFLT, BOOT_PC, BOOT_PC, 32'h55, 0, 0, 0);
        cyc(NO_E, NO_E, 32'h0008_0000, BOOT_PC, 32'd0, 0, 0, 0);
        idle(1);
        // Store fault, then mret back to the faulting PC.
        cyc(NO_E, E_SFLT, RUN_PC, 32'h0008_0010, 32'h0000_0100, 0, 0, 0);
        idle(2);
        cyc(NO_E, NO_E, RUN_PC, RUN_PC, 32'd0, 0, 0, 1);
        idle(2);
        // ecall returns past itself; mret outside the handler is ignored.
        cyc(NO_E, NO_E, RUN_PC, RUN_PC, 32'd0, 0, 0, 1);
        cyc(NO_E, E_ECALL, RUN_PC, 32'h0008_0020, 32'h77, 0, 0, 0);
        idle(2);
        cyc(NO_E, NO_E, RUN_PC, RUN_PC, 32'd0, 0, 0, 1);
        idle(2);
        // Fetch-stage illegal held by two stall cycles, trapped once it reaches E.
        cyc(E_ILL, NO_E, 32'h0008_0040, RUN_PC, 32'd0, 0, 0, 0);
        cyc(NO_E, NO_E, RUN_PC, RUN_PC, 32'd0, 1, 0, 0);
        cyc(NO_E, NO_E, RUN_PC, RUN_PC, 32'd0, 1, 0, 0);
        idle(4);
        cyc(NO_E, NO_E, RUN_PC, RUN_PC, 32'd0, 0, 0, 1);
        idle(2);
        // Same, but a hazard flush drops the carried fault.
        cyc(E_ILL, NO_E, 32'h0008_0040, RUN_PC, 32'd0, 0, 0, 0);
        cyc(NO_E, NO_E, RUN_PC, RUN_PC, 32'd0, 1, 1, 0);
        idle(4);
        // Load misaligned inside the handler: double fault, CSRs kept.
        cyc(NO_E, E_ECALL, RUN_PC, 32'h0008_0080, 32'd0, 0, 0, 0);
        idle(2);
        cyc(NO_E, E_LMIS, RUN_PC, 32'h0000_0010, 32'h0000_0123, 0, 0, 1);
        idle(3);
        // Reset while the trap entry redirect is on the bus.
        cyc(NO_E, E_LFLT, RUN_PC, 32'h0008_0090, 32'h0000_0200, 0, 0, 0);
        do_reset();
        idle(2);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                r  = $urandom_range(0, 29);
                cf = (r <= 8) ? 4'(r) : NO_E;
                r  = $urandom_range(0, 29);
                ce = (r <= 8) ? 4'(r) : NO_E;
                if ($urandom_range(0, 2) != 0) cf = NO_E;
                pf = ($urandom_range(0, 9) != 0) ? (RUN_PC | ($urandom() & 32'h0003_fffc))
                                                 : $urandom();
                cyc(cf, ce, pf, $urandom(), $urandom(),
                    $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 9) == 0);
            end
        end
        idle(3);
        chk32("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
